// File: rtl/calc_pkg.sv
// calc_pkg: opcode and FSM state types shared by the calculator core and its bench
package calc_pkg;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR, OP_PASS} op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_e;
endpackage

// File: rtl/calc_seq_core_if.sv
// calc_seq_core_if: start/operand/opcode request and result/flag/handshake bus; master drives requests, slave is the core
interface calc_seq_core_if #(parameter int width = 8);
  logic                 start_i;
  logic [width-1:0]     a_i;
  logic [width-1:0]     b_i;
  logic [2:0]           fct_i;
  logic [2*width-1:0]   s_o;
  logic                 signal_o;
  logic                 err_o;
  logic                 busy_o;
  logic                 done_o;
  modport master (output start_i, a_i, b_i, fct_i, input s_o, signal_o, err_o, busy_o, done_o);
  modport slave  (input start_i, a_i, b_i, fct_i, output s_o, signal_o, err_o, busy_o, done_o);
endinterface

// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative shift-add multiplier / restoring divider; load_i captures a_i,b_i, step_i runs one iteration, result_o is the post-step value (mode_i=1 divide)
module seq_muldiv #(
  parameter int width = 8
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 mode_i,
  input  logic [width-1:0]     a_i,
  input  logic [width-1:0]     b_i,
  output logic [2*width-1:0]   result_o
);
  logic [2*width-1:0] mcand_q, acc_q, acc_d;
  logic [width-1:0]   mplier_q, rem_q, quo_q, dvs_q, rem_d, quo_d;
  logic [width:0]     t;
  logic               ge;
  always_comb begin
    acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
    t        = {rem_q, quo_q[width-1]};
    ge       = t >= {1'b0, dvs_q};
    rem_d    = ge ? t[width-1:0] - dvs_q : t[width-1:0];
    quo_d    = {quo_q[width-2:0], ge};
    result_o = mode_i ? {rem_d, quo_d} : acc_d;
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
    end else if (load_i) begin
      mcand_q  <= {{width{1'b0}}, a_i};
      acc_q    <= '0;
      mplier_q <= b_i;
      rem_q    <= '0;
      quo_q    <= a_i;
      dvs_q    <= b_i;
    end else if (step_i) begin
      if (mode_i) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
      end else begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
    end
  end
endmodule

// File: rtl/calc_seq_core.sv
// calc_seq_core: handshaked calculator (clock_i, reset_i, bus: start/a/b/fct in, s/signal/err/busy/done out) with IDLE/EXEC/DONE FSM
module calc_seq_core
  import calc_pkg::*;
#(
  parameter int width = 8
) (
  input logic             clock_i,
  input logic             reset_i,
  calc_seq_core_if.slave  bus
);
  localparam int CNT_W = $clog2(width) + 1;
  state_e               state_q;
  op_e                  op_q, op_i;
  logic [width-1:0]     a_q, b_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*width-1:0]   s_q, res_d, md_res;
  logic                 sig_q, err_q, busy_q, done_q, load, long_op, sig_d, err_d;
  assign op_i    = op_e'(bus.fct_i);
  assign load    = (state_q != ST_EXEC) && bus.start_i;
  assign long_op = (op_i == OP_MUL) || (op_i == OP_DIV && bus.b_i != '0);
  seq_muldiv #(.width(width)) u_md (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .load_i   (load),
    .step_i   (state_q == ST_EXEC),
    .mode_i   (op_q == OP_DIV),
    .a_i      (bus.a_i),
    .b_i      (bus.b_i),
    .result_o (md_res)
  );
  always_comb begin
    res_d = '0;
    case (op_q)
      OP_ADD:  res_d = {{width{1'b0}}, a_q} + {{width{1'b0}}, b_q};
      OP_SUB:  res_d = {{width{1'b0}}, a_q} - {{width{1'b0}}, b_q};
      OP_MUL:  res_d = md_res;
      OP_DIV:  res_d = (b_q == '0) ? '1 : md_res;
      OP_AND:  res_d = {{width{1'b0}}, a_q & b_q};
      OP_OR:   res_d = {{width{1'b0}}, a_q | b_q};
      OP_XOR:  res_d = {{width{1'b0}}, a_q ^ b_q};
      OP_PASS: res_d = {{width{1'b0}}, a_q};
    endcase
    sig_d = (op_q == OP_SUB) && (a_q < b_q);
    err_d = (op_q == OP_DIV) && (b_q == '0);
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      sig_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_EXEC: begin
          if (cnt_q == '0) begin
            state_q <= ST_DONE;
            s_q     <= res_d;
            sig_q   <= sig_d;
            err_q   <= err_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          if (bus.start_i) begin
            state_q <= ST_EXEC;
            op_q    <= op_i;
            a_q     <= bus.a_i;
            b_q     <= bus.b_i;
            cnt_q   <= long_op ? CNT_W'(width - 1) : '0;
            s_q     <= '0;
            sig_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end
  assign bus.s_o      = s_q;
  assign bus.signal_o = sig_q;
  assign bus.err_o    = err_q;
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
endmodule

// File: tb/tb_calc_seq_core.sv
// tb_calc_seq_core: directed vectors with literal checks plus a cycle-timeline model compared every cycle
module tb_calc_seq_core;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  calc_seq_core_if #(.width(W)) bus ();
  calc_seq_core #(.width(W)) dut (.clock_i(clk), .reset_i(rst), .bus(bus));
  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int b_from = -10;
  int b_to = -10;
  int d_cyc = -10;
  int n_it;
  logic [15:0] pend, e_s;
  logic pend_sig, pend_err, e_sig, e_err;
  bit armed = 0;
  function automatic logic [15:0] calc(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y);
    case (f)
      3'd0: return 16'(x) + 16'(y);
      3'd1: return 16'(x) - 16'(y);
      3'd2: return 16'(x) * 16'(y);
      3'd3: return (y == 0) ? 16'hFFFF : {8'(x % y), 8'(x / y)};
      3'd4: return 16'(x & y);
      3'd5: return 16'(x | y);
      3'd6: return 16'(x ^ y);
      default: return 16'(x);
    endcase
  endfunction
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      b_from = -10;
      b_to   = -10;
      d_cyc  = -10;
      e_s    = 0;
      e_sig  = 0;
      e_err  = 0;
      armed  = 1;
    end else begin
      if (cyc + 1 == d_cyc) begin
        e_s   = pend;
        e_sig = pend_sig;
        e_err = pend_err;
      end
      if (bus.start_i && !(cyc >= b_from && cyc <= b_to)) begin
        n_it     = (bus.fct_i == 3'd2 || (bus.fct_i == 3'd3 && bus.b_i != 0)) ? W : 1;
        b_from   = cyc + 1;
        b_to     = cyc + n_it;
        d_cyc    = cyc + n_it + 1;
        pend     = calc(bus.fct_i, bus.a_i, bus.b_i);
        pend_sig = (bus.fct_i == 3'd1) && (bus.a_i < bus.b_i);
        pend_err = (bus.fct_i == 3'd3) && (bus.b_i == 0);
        e_s      = 0;
        e_sig    = 0;
        e_err    = 0;
      end
    end
    cyc++;
  end
  always @(negedge clk) begin
    if (armed) begin
      cmp("model_busy", bus.busy_o, (cyc >= b_from && cyc <= b_to));
      cmp("model_done", bus.done_o, (cyc == d_cyc));
      cmp("model_s", bus.s_o, e_s);
      cmp("model_signal", bus.signal_o, e_sig);
      cmp("model_err", bus.err_o, e_err);
    end
  end
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic go(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y);
    bus.fct_i   = f;
    bus.a_i     = x;
    bus.b_i     = y;
    bus.start_i = 1'b1;
  endtask
  task automatic wait_done(inout int n);
    while (!bus.done_o && n < 40) begin
      tick;
      n++;
    end
  endtask
  task automatic run(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y, input int lat,
                     input logic [15:0] s, input logic sg, input logic er);
    int n;
    go(f, x, y);
    tick;
    bus.start_i = 1'b0;
    cmp("busy_c1", bus.busy_o, 1);
    n = 1;
    wait_done(n);
    cmp("latency", n, lat);
    cmp("s_o", bus.s_o, s);
    cmp("signal_o", bus.signal_o, sg);
    cmp("err_o", bus.err_o, er);
    tick;
    cmp("done_drop", bus.done_o, 0);
    cmp("s_hold", bus.s_o, s);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    bus.start_i = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.fct_i   = '0;
    tick;
    tick;
    rst = 1'b0;
    cmp("rst_s", bus.s_o, 0);
    cmp("rst_busy", bus.busy_o, 0);
    cmp("rst_done", bus.done_o, 0);
    cmp("rst_flags", {bus.signal_o, bus.err_o}, 0);
    run(3'd0, 8'd200, 8'd100, 2, 16'h012C, 1'b0, 1'b0);
    run(3'd1, 8'd5, 8'd9, 2, 16'hFFFC, 1'b1, 1'b0);
    run(3'd1, 8'd9, 8'd5, 2, 16'h0004, 1'b0, 1'b0);
    go(3'd2, 8'd255, 8'd255);
    tick;
    bus.start_i = 1'b0;
    tick;
    tick;
    tick;
    go(3'd0, 8'd1, 8'd1);
    tick;
    bus.start_i = 1'b0;
    cmp("mul_busy_c5", bus.busy_o, 1);
    n = 5;
    wait_done(n);
    cmp("mul_latency", n, 9);
    cmp("mul_s", bus.s_o, 16'hFE01);
    tick;
    cmp("mul_idle", {bus.busy_o, bus.done_o}, 0);
    run(3'd3, 8'd200, 8'd7, 9, 16'h041C, 1'b0, 1'b0);
    run(3'd3, 8'd13, 8'd0, 2, 16'hFFFF, 1'b0, 1'b1);
    run(3'd3, 8'd7, 8'd200, 9, 16'h0700, 1'b0, 1'b0);
    run(3'd2, 8'd13, 8'd11, 9, 16'h008F, 1'b0, 1'b0);
    run(3'd5, 8'hA0, 8'h05, 2, 16'h00A5, 1'b0, 1'b0);
    run(3'd7, 8'h5A, 8'hFF, 2, 16'h005A, 1'b0, 1'b0);
    go(3'd6, 8'hF0, 8'h3C);
    tick;
    bus.fct_i = 3'd4;
    tick;
    cmp("b2b_done1", bus.done_o, 1);
    cmp("b2b_s1", bus.s_o, 16'h00CC);
    tick;
    bus.start_i = 1'b0;
    cmp("b2b_busy2", bus.busy_o, 1);
    cmp("b2b_nodone", bus.done_o, 0);
    cmp("b2b_clear", bus.s_o, 0);
    tick;
    cmp("b2b_done2", bus.done_o, 1);
    cmp("b2b_s2", bus.s_o, 16'h0030);
    tick;
    go(3'd2, 8'd100, 8'd3);
    tick;
    bus.start_i = 1'b0;
    tick;
    tick;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    cmp("mrst_busy", bus.busy_o, 0);
    cmp("mrst_done", bus.done_o, 0);
    cmp("mrst_s", bus.s_o, 0);
    cmp("mrst_flags", {bus.signal_o, bus.err_o}, 0);
    tick;
    cmp("mrst_nodone", bus.done_o, 0);
    run(3'd0, 8'd1, 8'd1, 2, 16'h0002, 1'b0, 1'b0);
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/calc_seq_core.md
Name: calc_seq_core

Overview:
- Next-generation calculator core: a parametrised, handshaked datapath replacing the fixed 4-function ALU and register top level.
- Adds iterative multiply and divide, logic ops, a divide-by-zero flag and a start/busy/done handshake.
- Sits between the operand-capture front end and the result display/readout.
- A single FSM owns operand capture, execution and result hold.

Parameters:
- width, 8: operand width in bits; legal range 2..32; result is 2*width.
- CNT_W, $clog2(width)+1: iteration counter width; derived, not to be overridden.

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  request; sampled only when ready (IDLE or DONE).
- a_i  in  width  operand A (unsigned).
- b_i  in  width  operand B (unsigned).
- fct_i  in  3  opcode:
  - 000 ADD, 001 SUB, 010 MUL, 011 DIV
  - 100 AND, 101 OR, 110 XOR, 111 PASS_A
- s_o  out  2*width  registered result; held until the next accepted start.
- signal_o  out  1  negative flag (SUB only).
- err_o  out  1  divide-by-zero flag.
- busy_o  out  1  high in EXEC.
- done_o  out  1  one-cycle pulse in DONE.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; s_o=0, signal_o=0, err_o=0, busy_o=0, done_o=0; counter and operand registers cleared. Reset wins over every other event, including mid-EXEC; any partial result is discarded.
- States: IDLE, EXEC, DONE.
- IDLE or DONE with start_i=1:
  - a_i, b_i, fct_i are latched.
  - Counter is loaded with N-1: N=width for MUL, and for DIV with b_i!=0; N=1 otherwise.
  - Next state is EXEC.
  - s_o, signal_o and err_o are cleared on the same edge.
- DONE with start_i=0: go to IDLE. IDLE with start_i=0: stay in IDLE. s_o, signal_o and err_o are unchanged in both cases.
- EXEC:
  - One iteration per cycle.
  - When counter=0, the result registers are written and the next state is DONE. Otherwise the counter is decremented.
  - start_i is ignored.
  - Operand inputs may change freely; only the latched copies are used.
- Latency: with start sampled at the end of cycle 0, EXEC occupies cycles 1..N and done_o=1 in cycle N+1 only. This gives cycle 2 for single-cycle ops and cycle width+1 for MUL/DIV.
- Back-to-back: start_i=1 during DONE is accepted. done_o still pulses for exactly that one cycle. The next EXEC begins the following cycle.
- Arithmetic:
  - ADD: s_o = zero-extended a+b, carry lands in bit width.
  - SUB: s_o = (a-b) sign-extended to 2*width; signal_o = (a<b).
  - MUL: unsigned shift-add, LSB first; s_o = a*b, full 2*width bits, no overflow possible.
  - DIV: restoring, unsigned; s_o = {remainder[width-1:0], quotient[width-1:0]}.
  - DIV with b=0: N=1, s_o = all ones, err_o=1.
  - Logic ops and PASS_A: zero-extended to 2*width.
- signal_o and err_o are 0 for every op other than those stated above.
- busy_o = (state==EXEC); done_o = (state==DONE). Both are registered decodes of state, with no combinational path from inputs.

Decomposition:
- Package calc_pkg:
  - Opcode typedef enum logic [2:0] (OP_ADD..OP_PASS).
  - State typedef enum (ST_IDLE, ST_EXEC, ST_DONE).
- Sub-module seq_muldiv #(width), owning shift registers and partial product/remainder.
  - Inputs: clock_i, reset_i, load_i, step_i, mode_i (mul/div), a_i, b_i.
  - Outputs: result_o[2*width-1:0].
  - calc_seq_core keeps the FSM, counter, single-cycle ops and output registers.

Test Plan (width=8):
- Reset then ADD a=200 b=100 -> s_o=0x012C, signal_o=0, done_o high in cycle 2 only, busy_o high in cycle 1 only.
- SUB a=5 b=9 -> s_o=0xFFFC, signal_o=1. Then SUB a=9 b=5 -> s_o=0x0004, signal_o=0.
- MUL a=255 b=255 -> busy_o for 8 cycles, done_o in cycle 9, s_o=0xFE01. start_i pulsed in cycle 4 with ADD is ignored, and the result is unchanged.
- DIV a=200 b=7 -> s_o=0x041C (remainder 4, quotient 28), done_o in cycle 9. DIV a=13 b=0 -> s_o=0xFFFF, err_o=1, done_o in cycle 2.
- Back-to-back: start held high across DONE with XOR a=0xF0 b=0x3C then AND a=0xF0 b=0x3C -> s_o=0x00CC, then s_o=0x0030, one done_o pulse each, no IDLE cycle between.
- Reset asserted in cycle 5 of a MUL -> next cycle: IDLE, all outputs 0, no done_o. A following ADD 1+1 -> s_o=0x0002 with normal latency.
